// File: rtl/tc_product_round_sat_if.sv
`default_nettype none
// ============================================================================
// Module   : tc_product_round_sat_if
// Brief    : Handshake and monitor bundle for the product shift/saturate stage.
// Revision : 1.0 - initial release
// ============================================================================
interface tc_product_round_sat_if #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_prod;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_ovf;
    logic                    clr_count;
    logic [CNT_W-1:0]        ovf_count;

    modport master (
        output in_valid, in_prod, out_ready, clr_count,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_prod, out_ready, clr_count,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/tc_product_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : tc_product_round_sat
// Brief    : Shifts a signed multiplier product right, saturates it to OUT_W
//            through a 2-stage elastic pipeline and counts overflows.
//            TC_PRODUCT_ROUND_NEAREST_EN selects round-half-up instead of floor.
// Revision : 1.0 - initial release
// ============================================================================
module tc_product_round_sat #(
    parameter int IN_W  = 33,
    parameter int SHIFT = 14,
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
) (
    input logic                   ap_clk,
    input logic                   ap_rst,
    tc_product_round_sat_if.slave bus
);

`ifdef TC_PRODUCT_ROUND_NEAREST_EN
    // One extra bit keeps the biased sum from wrapping at the top of the range.
    localparam int SH_W = IN_W - SHIFT + 1;
`else
    localparam int SH_W = IN_W - SHIFT;
`endif

    localparam logic signed [SH_W-1:0] SAT_MAX =
        {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] SAT_MIN =
        {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;
    logic                   in_fire;
    logic                   out_fire;
    logic signed [SH_W-1:0] sh_next;
    logic signed [SH_W-1:0] s1_sh;
    logic [OUT_W-1:0]       sat_data;
    logic                   sat_ovf;
    logic [OUT_W-1:0]       s2_data;
    logic                   s2_ovf;
    logic [CNT_W-1:0]       ovf_cnt;

`ifdef TC_PRODUCT_ROUND_NEAREST_EN
    logic signed [IN_W:0]   biased;

    generate
        if (SHIFT == 0) begin : g_no_bias
            assign biased = {bus.in_prod[IN_W-1], bus.in_prod};
        end else begin : g_bias
            localparam logic [IN_W:0] BIAS = (IN_W+1)'(1) << (SHIFT-1);
            logic [SHIFT-1:0] unused_frac_bits;

            assign biased           = {bus.in_prod[IN_W-1], bus.in_prod} + BIAS;
            assign unused_frac_bits = biased[SHIFT-1:0];
        end
    endgenerate

    assign sh_next = biased[IN_W:SHIFT];
`else
    generate
        if (SHIFT > 0) begin : g_drop_lsbs
            logic [SHIFT-1:0] unused_frac_bits;
            assign unused_frac_bits = bus.in_prod[SHIFT-1:0];
        end
    endgenerate

    // Slicing off the low bits is the arithmetic shift; the sign bit is kept.
    assign sh_next = bus.in_prod[IN_W-1:SHIFT];
`endif

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = s2_valid && bus.out_ready;

    always_comb begin
        sat_data = s1_sh[OUT_W-1:0];
        sat_ovf  = 1'b0;
        if (s1_sh > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end else if (s1_sh < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_ovf  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s1_sh    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sh    <= sh_next;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_data;
                s2_ovf  <= sat_ovf;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ovf_cnt <= '0;
        end else if (bus.clr_count) begin
            ovf_cnt <= '0;
        end else if (out_fire && s2_ovf && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_ovf   = s2_ovf;
    assign bus.ovf_count = ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tc_product_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_product_round_sat
// Brief    : Self-checking bench for tc_product_round_sat against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_product_round_sat;
    localparam int IN_W  = 33;
    localparam int SHIFT = 14;
    localparam int OUT_W = 14;
    localparam int CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int unsigned cnt_model;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tc_product_round_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    tc_product_round_sat #(
        .IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (bus.slave)
    );

    // Value-level reference: exact integer shift, optional bias, clamp.
    function automatic exp_t model(input logic signed [IN_W-1:0] p);
        longint v, mx, mn;
        exp_t   e;
        v = longint'(p);
`ifdef TC_PRODUCT_ROUND_NEAREST_EN
        if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT-1));
`endif
        v  = v >>> SHIFT;
        mx = (longint'(1) <<< (OUT_W-1)) - 1;
        mn = -mx - 1;
        if (v > mx)      begin e.d = OUT_W'(mx); e.o = 1'b1; end
        else if (v < mn) begin e.d = OUT_W'(mn); e.o = 1'b1; end
        else             begin e.d = OUT_W'(v);  e.o = 1'b0; end
        return e;
    endfunction

    // One clock: observe handshakes mid-cycle, update scoreboard and counter model.
    task automatic tick(output bit acc, output bit pop, output logic [OUT_W-1:0] gd,
                        output logic go, output exp_t ex, output bit hx);
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        pop = bus.out_valid && bus.out_ready;
        gd  = bus.out_data;
        go  = bus.out_ovf;
        hx  = 1'b0;
        ex  = '0;
        if (pop && exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            hx = 1'b1;
        end
        if (acc) exp_q.push_back(model(bus.in_prod));
        if (bus.clr_count) cnt_model = 0;
        else if (pop && hx && ex.o && cnt_model < CNT_MAX) cnt_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counter();
        bit a, p, o2, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        bus.clr_count = 1'b1;
        tick(a, p, d, o, e, h);
        bus.clr_count = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_prod = '0; bus.out_ready = 1'b0; bus.clr_count = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got=%0d want=0", bus.out_data); end
        n_cmp++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf); end
        n_cmp++; if (bus.ovf_count !== '0) begin n_bad++; $display("FAIL reset_ovf_count got=%0d want=0", bus.ovf_count); end
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic signed [IN_W-1:0]  vals [3];
        logic signed [OUT_W-1:0] want [3];
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        vals[0] = IN_W'(16384); vals[1] = IN_W'(1048576); vals[2] = -IN_W'(16384);
        want[0] = OUT_W'(1);    want[1] = OUT_W'(64);     want[2] = -OUT_W'(1);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            bus.in_valid = (t < 3);
            bus.in_prod  = (t < 3) ? vals[t] : '0;
            tick(a, p, d, o, e, h);
            if (t < 3) begin
                n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL basic_accept[%0d] got=%b want=1", t, a); end
            end
            if (t == 1) begin
                n_cmp++; if (p !== 1'b0) begin n_bad++; $display("FAIL basic_latency early out_valid got=%b want=0", p); end
            end
            if (t >= 2 && t <= 4) begin
                n_cmp++;
                if (p !== 1'b1 || d !== want[t-2] || o !== 1'b0 || !h || d !== e.d) begin
                    n_bad++;
                    $display("FAIL basic_data[%0d] got valid=%b data=%0d ovf=%b want valid=1 data=%0d ovf=0",
                             t-2, p, $signed(d), o, want[t-2]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [IN_W-1:0]  vals [3];
        logic signed [OUT_W-1:0] want [3];
        logic                    wovf [3];
        int idx, npop, guard;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        vals[0] = IN_W'(64'sd1 <<< 30); vals[1] = -(IN_W'(64'sd1 <<< 31)); vals[2] = IN_W'(64'sd8191 <<< 14);
        want[0] = OUT_W'(8191); want[1] = -OUT_W'(8192); want[2] = OUT_W'(8191);
        wovf[0] = 1'b1; wovf[1] = 1'b1; wovf[2] = 1'b0;
        clear_counter();
        bus.out_ready = 1'b1;
        idx = 0; npop = 0; guard = 0;
        while (npop < 3 && guard < 30) begin
            bus.in_valid = (idx < 3);
            bus.in_prod  = (idx < 3) ? vals[idx] : '0;
            tick(a, p, d, o, e, h);
            if (a) idx++;
            if (p) begin
                n_cmp++;
                if (d !== want[npop] || o !== wovf[npop] || !h || d !== e.d || o !== e.o) begin
                    n_bad++;
                    $display("FAIL sat_data[%0d] got data=%0d ovf=%b want data=%0d ovf=%b",
                             npop, $signed(d), o, want[npop], wovf[npop]);
                end
                npop++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (npop != 3) begin n_bad++; $display("FAIL sat_timeout got=%0d results want=3", npop); end
        n_cmp++; if (bus.ovf_count !== CNT_W'(2)) begin n_bad++; $display("FAIL sat_ovf_count got=%0d want=2", bus.ovf_count); end
    endtask

    task automatic test_rounding();
        logic signed [IN_W-1:0]  vals [3];
        logic signed [OUT_W-1:0] want [3];
        int idx, npop, guard;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        vals[0] = IN_W'(24576); vals[1] = -IN_W'(24576); vals[2] = IN_W'(8191);
`ifdef TC_PRODUCT_ROUND_NEAREST_EN
        want[0] = OUT_W'(2); want[1] = -OUT_W'(1); want[2] = OUT_W'(0);
`else
        want[0] = OUT_W'(1); want[1] = -OUT_W'(2); want[2] = OUT_W'(0);
`endif
        bus.out_ready = 1'b1;
        idx = 0; npop = 0; guard = 0;
        while (npop < 3 && guard < 30) begin
            bus.in_valid = (idx < 3);
            bus.in_prod  = (idx < 3) ? vals[idx] : '0;
            tick(a, p, d, o, e, h);
            if (a) idx++;
            if (p) begin
                n_cmp++;
                if (d !== want[npop] || o !== 1'b0 || !h || d !== e.d) begin
                    n_bad++;
                    $display("FAIL round_data[%0d] got data=%0d ovf=%b want data=%0d ovf=0",
                             npop, $signed(d), o, want[npop]);
                end
                npop++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (npop != 3) begin n_bad++; $display("FAIL round_timeout got=%0d results want=3", npop); end
    endtask

    task automatic test_backpressure();
        logic signed [IN_W-1:0] vals [3];
        logic [OUT_W-1:0] held;
        int idx, accepted, npop, guard;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        vals[0] = IN_W'(64'sd100 <<< 14); vals[1] = IN_W'(64'sd200 <<< 14); vals[2] = -IN_W'(64'sd300 <<< 14);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        idx = 0; accepted = 0;
        for (int t = 0; t < 3; t++) begin
            bus.in_prod = vals[idx];
            tick(a, p, d, o, e, h);
            if (a) begin idx++; accepted++; end
        end
        n_cmp++; if (accepted != 2) begin n_bad++; $display("FAIL bp_accepted got=%0d want=2", accepted); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid got=%b want=1", bus.out_valid); end
        held = bus.out_data;
        for (int t = 0; t < 3; t++) begin
            bus.in_prod = vals[idx];
            tick(a, p, d, o, e, h);
            if (a) idx++;
            n_cmp++; if (d !== held || a) begin n_bad++; $display("FAIL bp_stall_stable got=%0d acc=%b want=%0d acc=0", $signed(d), a, $signed(held)); end
        end
        bus.out_ready = 1'b1;
        npop = 0; guard = 0;
        while ((idx < 3 || exp_q.size() > 0) && guard < 30) begin
            bus.in_valid = (idx < 3);
            bus.in_prod  = (idx < 3) ? vals[idx] : '0;
            tick(a, p, d, o, e, h);
            if (a) idx++;
            if (p) begin
                n_cmp++;
                if (!h || d !== e.d || o !== e.o) begin
                    n_bad++;
                    $display("FAIL bp_order[%0d] got data=%0d ovf=%b want data=%0d ovf=%b expected_present=%b",
                             npop, $signed(d), o, $signed(e.d), e.o, h);
                end
                npop++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick(a, p, d, o, e, h);
            if (p) npop++;
        end
        n_cmp++; if (npop != 3) begin n_bad++; $display("FAIL bp_count got=%0d results want=3", npop); end
    endtask

    task automatic test_random();
        longint v;
        logic [IN_W-1:0] r;
        int guard;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        for (int t = 0; t < 3000; t++) begin
            case ($urandom_range(0, 3))
                0: r = {1'($urandom_range(0, 1)), $urandom};
                1: begin v = (longint'(8191) <<< SHIFT) + longint'($urandom_range(0, 40000)) - 20000; r = v[IN_W-1:0]; end
                2: begin v = -(longint'(8192) <<< SHIFT) + longint'($urandom_range(0, 40000)) - 20000; r = v[IN_W-1:0]; end
                default: begin v = longint'($urandom_range(0, 131072)) - 65536; r = v[IN_W-1:0]; end
            endcase
            bus.in_prod   = r;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.clr_count = ($urandom_range(0, 63) == 0);
            tick(a, p, d, o, e, h);
            if (p) begin
                n_cmp++;
                if (!h || d !== e.d || o !== e.o) begin
                    n_bad++;
                    $display("FAIL rand_data t=%0d got data=%0d ovf=%b want data=%0d ovf=%b expected_present=%b",
                             t, $signed(d), o, $signed(e.d), e.o, h);
                end
            end
            if (t % 16 == 0) begin
                n_cmp++;
                if (bus.ovf_count !== CNT_W'(cnt_model)) begin
                    n_bad++;
                    $display("FAIL rand_ovf_count t=%0d got=%0d want=%0d", t, bus.ovf_count, cnt_model);
                end
            end
        end
        bus.in_valid = 1'b0; bus.clr_count = 1'b0; bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            tick(a, p, d, o, e, h);
            if (p) begin
                n_cmp++;
                if (!h || d !== e.d || o !== e.o) begin n_bad++; $display("FAIL rand_drain got=%0d want=%0d", $signed(d), $signed(e.d)); end
            end
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_drain_timeout got=%0d left want=0", exp_q.size()); end
        n_cmp++; if (bus.ovf_count !== CNT_W'(cnt_model)) begin n_bad++; $display("FAIL rand_final_count got=%0d want=%0d", bus.ovf_count, cnt_model); end
    endtask

    task automatic test_counter_bounds();
        int nsent, npop, guard;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        clear_counter();
        bus.out_ready = 1'b1;
        bus.in_prod   = IN_W'(64'sd1 <<< 30);
        nsent = 0; npop = 0; guard = 0;
        while (npop < 65538 && guard < 66000) begin
            bus.in_valid = (nsent < 65538);
            tick(a, p, d, o, e, h);
            if (a) nsent++;
            if (p) npop++;
            guard++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (npop != 65538) begin n_bad++; $display("FAIL cnt_timeout got=%0d results want=65538", npop); end
        n_cmp++; if (bus.ovf_count !== CNT_W'(CNT_MAX)) begin n_bad++; $display("FAIL cnt_saturate got=%0d want=%0d", bus.ovf_count, CNT_MAX); end
        n_cmp++; if (bus.ovf_count !== CNT_W'(cnt_model)) begin n_bad++; $display("FAIL cnt_model got=%0d want=%0d", bus.ovf_count, cnt_model); end

        // Park one overflow result at the output, then pop it while clearing.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick(a, p, d, o, e, h);
        bus.in_valid  = 1'b0;
        tick(a, p, d, o, e, h);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ovf !== 1'b1) begin n_bad++; $display("FAIL cnt_park got valid=%b ovf=%b want 1/1", bus.out_valid, bus.out_ovf); end
        bus.out_ready = 1'b1;
        bus.clr_count = 1'b1;
        tick(a, p, d, o, e, h);
        bus.clr_count = 1'b0;
        n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL cnt_clr_pop got=%b want=1", p); end
        n_cmp++; if (bus.ovf_count !== '0) begin n_bad++; $display("FAIL cnt_clr_priority got=%0d want=0", bus.ovf_count); end
    endtask

    task automatic test_reset_mid();
        int npop, guard, nacc;
        bit a, p, h; logic [OUT_W-1:0] d; logic o; exp_t e;
        bus.out_ready = 1'b1;
        bus.in_prod   = IN_W'(64'sd1 <<< 30);
        bus.in_valid  = 1'b1;
        tick(a, p, d, o, e, h);
        bus.in_valid  = 1'b0;
        npop = 0; guard = 0;
        while (npop < 1 && guard < 10) begin
            tick(a, p, d, o, e, h);
            if (p) npop++;
            guard++;
        end
        n_cmp++; if (bus.ovf_count !== CNT_W'(1)) begin n_bad++; $display("FAIL rstmid_pre_count got=%0d want=1", bus.ovf_count); end

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        nacc = 0;
        for (int t = 0; t < 2; t++) begin
            bus.in_prod = IN_W'(64'sd5 <<< 14);
            tick(a, p, d, o, e, h);
            if (a) nacc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (nacc != 2 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_fill got acc=%0d valid=%b want 2/1", nacc, bus.out_valid); end

        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.ovf_count !== '0) begin n_bad++; $display("FAIL rstmid_ovf_count got=%0d want=0", bus.ovf_count); end
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_prod   = IN_W'(1048576);
        for (int t = 0; t < 6; t++) begin
            tick(a, p, d, o, e, h);
            bus.in_valid = 1'b0;
            if (t == 0) begin
                n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rstmid_accept got=%b want=1", a); end
            end else if (t == 2) begin
                n_cmp++; if (p !== 1'b1 || d !== OUT_W'(64) || o !== 1'b0) begin n_bad++; $display("FAIL rstmid_first got valid=%b data=%0d ovf=%b want 1/64/0", p, $signed(d), o); end
            end else begin
                n_cmp++; if (p !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale t=%0d got valid=%b want=0", t, p); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_random();
        test_counter_bounds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
